aes_round_sequencer: RTL and testbench
======================================

Name: aes_round_sequencer

Overview:
- Iterative AES encryption round controller; owns no datapath, only sequences it.
- Accepts a block-start handshake, then requests round keys one at a time from the key-expansion unit.
- Drives load enable and round-type select to the shared round datapath: AddRoundKey, SubBytes, ShiftRows, MixColumns and the 128-bit state register.
- Presents a result-valid handshake with backpressure and a block-completion counter.

Parameters:
- NR, 10, number of AES rounds; legal values 10/12/14, other values unsupported.
- CNT_W, 16, width of the completed-block counter.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  new block (plaintext and cipher key) present at datapath inputs.
- in_ready  out  1  sequencer can accept a block.
- key_req  out  1  round-key request to key expansion.
- key_round  out  4  index of the requested round key, 0..NR.
- key_valid  in  1  requested round key present on the datapath key bus.
- dp_en  out  1  state register load enable, single-cycle pulse.
- dp_sel  out  2  round type: 0=INIT (input XOR key), 1=FULL (Sub, Shift, Mix, ARK), 2=FINAL (Sub, Shift, ARK), 3 unused.
- round_num  out  4  current round index.
- busy  out  1  block in flight (not IDLE).
- out_valid  out  1  state register holds the ciphertext.
- out_ready  in  1  consumer accepts the ciphertext.
- blk_count  out  CNT_W  completed blocks, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync-released by the system): state=IDLE; round_num=0, key_round=0, key_req=0, dp_en=0, dp_sel=0, out_valid=0, busy=0, blk_count=0; in_ready=1.
- FSM states: IDLE, KREQ, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid (handshake fires): round_num<=0, go to KREQ.
  - No dp_en in this cycle.
- KREQ:
  - key_req=1 and key_round=round_num, both held stable until key_valid is sampled high.
  - key_valid is ignored whenever key_req=0.
  - In the cycle key_valid=1: dp_en=1 (combinational, same cycle), dp_sel = INIT if round_num=0, FINAL if round_num=NR, else FULL.
  - If round_num<NR: round_num<=round_num+1, stay in KREQ.
  - If round_num=NR: go to DONE.
  - No dp_en in any cycle with key_valid=0 (key stalls of any length).
- DONE:
  - out_valid=1, key_req=0, in_ready=0.
  - On out_ready: out_valid drops next cycle, blk_count<=blk_count+1, go to IDLE.
  - No same-cycle bypass to a new block; in_valid is sampled only in IDLE.
- busy=1 in KREQ and DONE.
- dp_en fires exactly NR+1 times per block: sequence INIT, FULL×(NR-1), FINAL.
- Latency, with key_valid tied high and accept at cycle 0:
  - dp_en at cycles 1..NR+1.
  - out_valid first high at cycle NR+2.
  - in_ready high again the cycle after the out_ready handshake.
- Boundary conditions:
  - in_valid while busy: ignored, in_ready=0.
  - blk_count wraps from all-ones to 0.
  - round_num never exceeds NR.
  - Async reset mid-block: all outputs return to reset values immediately; the in-flight block is discarded with no dp_en and no out_valid.
  - out_ready held low: out_valid, round_num and blk_count hold indefinitely.

Test Plan:
- Reset, then in_valid pulse with key_valid=1 constantly, NR=10 -> dp_en at cycles 1..11, dp_sel sequence 0,1×9,2; key_round 0..10; out_valid at cycle 12; blk_count=1 after out_ready.
- Key stalls: key_valid low 3 cycles before every key -> key_req/key_round stable during stalls; 11 dp_en pulses total; out_valid at cycle 12+33=45.
- Backpressure: out_ready low 5 cycles in DONE -> out_valid held 6 cycles; in_valid during DONE ignored (in_ready=0); the next block starts only after return to IDLE.
- Async reset asserted during round 5 -> all outputs at reset values the same cycle; next block completes normally with blk_count=1.
- NR=14 build -> 15 dp_en pulses, FINAL on key_round=14; NR=12 -> FINAL on key_round=12.
- CNT_W=4, 17 back-to-back blocks -> blk_count reads 0 then 1 (wrap).

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption round controller: sequences key requests and
// round-type selects for a shared round datapath, with result handshake.
module aes_round_sequencer #(
    parameter int NR    = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             key_req,
    output logic [3:0]       key_round,
    input  logic             key_valid,
    output logic             dp_en,
    output logic [1:0]       dp_sel,
    output logic [3:0]       round_num,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] blk_count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_KREQ = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] NR_L      = 4'(NR);
    localparam logic [1:0] SEL_INIT  = 2'd0;
    localparam logic [1:0] SEL_FULL  = 2'd1;
    localparam logic [1:0] SEL_FINAL = 2'd2;

    state_t           r_state;
    logic [3:0]       r_round;
    logic [CNT_W-1:0] r_blk_count;

    logic w_in_kreq;
    logic w_key_fire;

    assign w_in_kreq  = (r_state == S_KREQ);
    // key_valid only matters while a request is outstanding
    assign w_key_fire = w_in_kreq && key_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_round     <= 4'd0;
            r_blk_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_round <= 4'd0;
                        r_state <= S_KREQ;
                    end
                end
                S_KREQ: begin
                    if (key_valid) begin
                        if (r_round == NR_L) begin
                            r_state <= S_DONE;
                        end else begin
                            r_round <= r_round + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_blk_count <= r_blk_count + 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // All outputs decode async-reset registers, so reset is visible at once
    always_comb begin
        dp_sel = SEL_INIT;
        if (w_in_kreq) begin
            if (r_round == 4'd0) begin
                dp_sel = SEL_INIT;
            end else if (r_round == NR_L) begin
                dp_sel = SEL_FINAL;
            end else begin
                dp_sel = SEL_FULL;
            end
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign key_req   = w_in_kreq;
    assign key_round = r_round;
    assign dp_en     = w_key_fire;
    assign round_num = r_round;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign blk_count = r_blk_count;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer: NR=10 main instance plus
// NR=14, NR=12 and CNT_W=4 instances for build-parameter boundaries.
module tb_aes_round_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main instance (NR=10, CNT_W=16)
    logic        in_valid = 1'b0, key_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, key_req, dp_en, busy, out_valid;
    logic [3:0]  key_round, round_num;
    logic [1:0]  dp_sel;
    logic [15:0] blk_count;

    // shared aux controls
    logic a_key_valid = 1'b1, a_out_ready = 1'b1;
    logic a_in14 = 1'b0, a_in12 = 1'b0, a_in4 = 1'b0;

    logic       r14_in_ready, r14_key_req, r14_dp_en, r14_busy, r14_out_valid;
    logic [3:0] r14_key_round, r14_round_num;
    logic [1:0] r14_dp_sel;
    logic [15:0] r14_blk_count;

    logic       r12_in_ready, r12_key_req, r12_dp_en, r12_busy, r12_out_valid;
    logic [3:0] r12_key_round, r12_round_num;
    logic [1:0] r12_dp_sel;
    logic [15:0] r12_blk_count;

    logic       c4_in_ready, c4_key_req, c4_dp_en, c4_busy, c4_out_valid;
    logic [3:0] c4_key_round, c4_round_num;
    logic [1:0] c4_dp_sel;
    logic [3:0] c4_blk_count;

    aes_round_sequencer #(.NR(10), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .key_req(key_req), .key_round(key_round), .key_valid(key_valid),
        .dp_en(dp_en), .dp_sel(dp_sel), .round_num(round_num), .busy(busy),
        .out_valid(out_valid), .out_ready(out_ready), .blk_count(blk_count)
    );

    aes_round_sequencer #(.NR(14), .CNT_W(16)) dut14 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in14), .in_ready(r14_in_ready),
        .key_req(r14_key_req), .key_round(r14_key_round), .key_valid(a_key_valid),
        .dp_en(r14_dp_en), .dp_sel(r14_dp_sel), .round_num(r14_round_num), .busy(r14_busy),
        .out_valid(r14_out_valid), .out_ready(a_out_ready), .blk_count(r14_blk_count)
    );

    aes_round_sequencer #(.NR(12), .CNT_W(16)) dut12 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in12), .in_ready(r12_in_ready),
        .key_req(r12_key_req), .key_round(r12_key_round), .key_valid(a_key_valid),
        .dp_en(r12_dp_en), .dp_sel(r12_dp_sel), .round_num(r12_round_num), .busy(r12_busy),
        .out_valid(r12_out_valid), .out_ready(a_out_ready), .blk_count(r12_blk_count)
    );

    aes_round_sequencer #(.NR(10), .CNT_W(4)) dutc4 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in4), .in_ready(c4_in_ready),
        .key_req(c4_key_req), .key_round(c4_key_round), .key_valid(a_key_valid),
        .dp_en(c4_dp_en), .dp_sel(c4_dp_sel), .round_num(c4_round_num), .busy(c4_busy),
        .out_valid(c4_out_valid), .out_ready(a_out_ready), .blk_count(c4_blk_count)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  in_ready, 1);
        chk({tag, "_key_req"},   key_req, 0);
        chk({tag, "_key_round"}, key_round, 0);
        chk({tag, "_dp_en"},     dp_en, 0);
        chk({tag, "_dp_sel"},    dp_sel, 0);
        chk({tag, "_round_num"}, round_num, 0);
        chk({tag, "_busy"},      busy, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_blk_count"}, blk_count, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndp, n14, n12, f14, f12, k14, k12, t;
        logic [1:0] exp_sel;

        // reset
        repeat (3) tick();
        chk_reset_vals("rst");
        rst_n = 1'b1;
        tick();

        // T1: key_valid tied high, single block
        in_valid = 1'b1; key_valid = 1'b1; out_ready = 1'b0;
        #1;
        chk("t1_accept_ready", in_ready, 1);
        chk("t1_idle_no_dp_en", dp_en, 0);
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            #1;
            exp_sel = (c == 1) ? 2'd0 : ((c == 11) ? 2'd2 : 2'd1);
            chk($sformatf("t1_dp_en_c%0d", c), dp_en, 1);
            chk($sformatf("t1_dp_sel_c%0d", c), dp_sel, exp_sel);
            chk($sformatf("t1_key_round_c%0d", c), key_round, c - 1);
            chk($sformatf("t1_round_num_c%0d", c), round_num, c - 1);
            tick();
        end
        chk("t1_out_valid_c12", out_valid, 1);
        chk("t1_done_no_dp_en", dp_en, 0);
        chk("t1_done_key_req", key_req, 0);
        chk("t1_done_in_ready", in_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("t1_out_valid_drop", out_valid, 0);
        chk("t1_blk_count", blk_count, 1);
        chk("t1_in_ready_back", in_ready, 1);
        chk("t1_busy_idle", busy, 0);

        // T2: three stall cycles before every key
        in_valid = 1'b1; key_valid = 1'b0;
        tick();
        in_valid = 1'b0;
        ndp = 0;
        for (int c = 1; c <= 44; c++) begin
            key_valid = (((c - 1) % 4) == 3);
            #1;
            chk($sformatf("t2_key_req_c%0d", c), key_req, 1);
            chk($sformatf("t2_key_round_c%0d", c), key_round, (c - 1) / 4);
            chk($sformatf("t2_dp_en_c%0d", c), dp_en, key_valid);
            if (dp_en) ndp++;
            chk($sformatf("t2_out_valid_c%0d", c), out_valid, 0);
            tick();
        end
        key_valid = 1'b0;
        #1;
        chk("t2_out_valid_c45", out_valid, 1);
        chk("t2_dp_en_count", ndp, 11);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("t2_blk_count", blk_count, 2);

        // T3: backpressure with in_valid asserted during DONE
        in_valid = 1'b1; key_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (11) tick();
        in_valid = 1'b1;
        for (int c = 12; c <= 16; c++) begin
            #1;
            chk($sformatf("t3_out_valid_c%0d", c), out_valid, 1);
            chk($sformatf("t3_in_ready_c%0d", c), in_ready, 0);
            chk($sformatf("t3_round_num_c%0d", c), round_num, 10);
            chk($sformatf("t3_blk_hold_c%0d", c), blk_count, 2);
            chk($sformatf("t3_busy_c%0d", c), busy, 1);
            tick();
        end
        chk("t3_out_valid_c17", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("t3_idle_in_ready", in_ready, 1);
        chk("t3_idle_out_valid", out_valid, 0);
        chk("t3_idle_no_dp_en", dp_en, 0);
        chk("t3_blk_count", blk_count, 3);
        tick();
        in_valid = 1'b0;
        #1;
        chk("t3_next_busy", busy, 1);
        chk("t3_next_dp_en", dp_en, 1);
        chk("t3_next_dp_sel", dp_sel, 0);

        // T4: async reset during round 5
        repeat (5) tick();
        chk("t4_round5", round_num, 5);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("t4_async");
        repeat (2) tick();
        chk("t4_hold_dp_en", dp_en, 0);
        chk("t4_hold_out_valid", out_valid, 0);
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (11) tick();
        chk("t4_out_valid", out_valid, 1);
        chk("t4_blk_before", blk_count, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        chk("t4_blk_after", blk_count, 1);

        // T5: NR=14 and NR=12 builds
        a_in14 = 1'b1; a_in12 = 1'b1;
        tick();
        a_in14 = 1'b0; a_in12 = 1'b0;
        n14 = 0; n12 = 0; f14 = 0; f12 = 0; k14 = 0; k12 = 0;
        for (int c = 1; c <= 20; c++) begin
            if (r14_dp_en) begin
                n14++;
                if (r14_dp_sel == 2'd2) begin f14++; k14 = int'(r14_key_round); end
            end
            if (r12_dp_en) begin
                n12++;
                if (r12_dp_sel == 2'd2) begin f12++; k12 = int'(r12_key_round); end
            end
            tick();
        end
        chk("t5_nr14_dp_en_count", n14, 15);
        chk("t5_nr14_final_count", f14, 1);
        chk("t5_nr14_final_round", k14, 14);
        chk("t5_nr12_dp_en_count", n12, 13);
        chk("t5_nr12_final_count", f12, 1);
        chk("t5_nr12_final_round", k12, 12);
        chk("t5_nr14_blk", r14_blk_count, 1);
        chk("t5_nr12_blk", r12_blk_count, 1);

        // T6: CNT_W=4 wrap over 17 back-to-back blocks
        a_in4 = 1'b1;
        for (int b = 1; b <= 17; b++) begin
            t = 0;
            while (!c4_out_valid && t < 20) begin
                tick();
                t++;
            end
            chk($sformatf("t6_done_blk%0d", b), c4_out_valid, 1);
            tick();
            if (b == 16) chk("t6_wrap_zero", c4_blk_count, 0);
            if (b == 17) chk("t6_wrap_one", c4_blk_count, 1);
        end
        a_in4 = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
